// File: rtl/dti_elastic_fifo_if.sv
// dti: DTI valid/ready channel carrying one data word per handshake.
// A word moves on any clock edge where valid and ready are both high. Once valid is raised,
// the producer keeps it and the data stable until ready is seen. Only a reset or flush may retract it.
interface dti #(
    parameter int W = 16
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dti_elastic_fifo.sv
// dti_elastic_fifo: arbitrary-depth DTI elastic buffer with occupancy, almost-full and sync flush.
// Define DTI_ELASTIC_FIFO_BYPASS_EN for zero-latency pass-through while the buffer is empty.
module dti_elastic_fifo #(
    parameter int DEPTH     = 4,
    parameter int DIN       = 16,
    parameter int AF_THRESH = DEPTH - 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    dti.consumer          din,
    dti.producer          dout,
    output logic [CW-1:0] count,
    output logic          almost_full
);
    localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

    logic [DIN-1:0] mem [DEPTH];
    logic [IW-1:0]  w_idx;
    logic [IW-1:0]  r_idx;
    logic           full;
    logic           empty;
    logic           pass;
    logic           wr;
    logic           rd;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign din.ready   = ~full;
    assign almost_full = (count >= AF_CNT);

`ifdef DTI_ELASTIC_FIFO_BYPASS_EN
    // An incoming word is offered straight to dout while empty. It is stored only when dout stalls.
    assign pass       = empty & din.valid & dout.ready;
    assign dout.valid = ~empty | din.valid;
    assign dout.data  = empty ? din.data : mem[r_idx];
`else
    assign pass       = 1'b0;
    assign dout.valid = ~empty;
    assign dout.data  = mem[r_idx];
`endif

    assign wr = din.valid & ~full & ~pass & ~flush;
    assign rd = dout.ready & ~empty;

    always_ff @(posedge clk) begin
        if (wr && !rst) begin
            mem[w_idx] <= din.data;
        end
    end

    // Indices wrap by explicit compare, so any DEPTH works.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            w_idx <= '0;
            r_idx <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                w_idx <= (w_idx == LAST_IDX) ? '0 : w_idx + IW'(1);
            end
            if (rd) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_dti_elastic_fifo.sv
// Bench for dti_elastic_fifo: four instances (DEPTH 4,5,3,2), directed scenarios plus a
// randomized run against a queue model of the buffer.
module tb_dti_elastic_fifo;
`ifdef DTI_ELASTIC_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTHS [4] = '{4, 5, 3, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_data  [4];
    logic        i_valid [4];
    logic        o_ready [4];
    logic        fl      [4];
    logic        i_ready [4];
    logic        o_valid [4];
    logic [15:0] o_data  [4];
    logic [2:0]  cnt     [4];
    logic        af      [4];

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int CW = $clog2(DEPTHS[g] + 1);
        logic [CW-1:0] c;
        dti #(.W(16)) in_if ();
        dti #(.W(16)) out_if ();
        assign in_if.data   = i_data[g];
        assign in_if.valid  = i_valid[g];
        assign out_if.ready = o_ready[g];
        assign i_ready[g]   = in_if.ready;
        assign o_valid[g]   = out_if.valid;
        assign o_data[g]    = out_if.data;
        assign cnt[g]       = 3'(c);
        dti_elastic_fifo #(.DEPTH(DEPTHS[g]), .DIN(16)) u_dut (
            .clk(clk), .rst(rst), .flush(fl[g]), .din(in_if), .dout(out_if),
            .count(c), .almost_full(af[g])
        );
    end

    task automatic drive(input int g, input logic v, input logic [15:0] d,
                         input logic r, input logic f);
        i_valid[g] = v;
        i_data[g]  = d;
        o_ready[g] = r;
        fl[g]      = f;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int g = 0; g < 4; g++) drive(g, 1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int g = 0; g < 4; g++) begin
            n_tests++; if (cnt[g] !== 3'd0) begin n_fail++; $display("FAIL reset_count[%0d] got %0d want 0", g, cnt[g]); end
            n_tests++; if (o_valid[g] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %b want 0", g, o_valid[g]); end
            n_tests++; if (i_ready[g] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d] got %b want 1", g, i_ready[g]); end
            n_tests++; if (af[g] !== 1'b0) begin n_fail++; $display("FAIL reset_af[%0d] got %b want 0", g, af[g]); end
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b1, 16'(16'h11 + i), 1'b0, 1'b0);
            #1;
            n_tests++; if (i_ready[1] !== 1'b1) begin n_fail++; $display("FAIL fill_ready push %0d got %b want 1", i, i_ready[1]); end
            tick();
            n_tests++; if (cnt[1] !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count got %0d want %0d", cnt[1], i + 1); end
            n_tests++; if (af[1] !== (i + 1 >= 4)) begin n_fail++; $display("FAIL fill_af at %0d got %b want %b", i + 1, af[1], (i + 1 >= 4)); end
        end
        drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        n_tests++; if (i_ready[1] !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", i_ready[1]); end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b0, 16'h0, 1'b1, 1'b0);
            #1;
            n_tests++; if (o_valid[1] !== 1'b1 || o_data[1] !== 16'(16'h11 + i)) begin n_fail++; $display("FAIL drain_data %0d got %b/%h want 1/%h", i, o_valid[1], o_data[1], 16'(16'h11 + i)); end
            tick();
            if (i == 0) begin
                n_tests++; if (i_ready[1] !== 1'b1) begin n_fail++; $display("FAIL drain_ready_rise got %b want 1", i_ready[1]); end
            end
        end
        n_tests++; if (cnt[1] !== 3'd0 || o_valid[1] !== 1'b0) begin n_fail++; $display("FAIL drain_empty got count %0d valid %b want 0/0", cnt[1], o_valid[1]); end
        drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [15:0] w [10];
        for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
        for (int i = 0; i <= 10; i++) begin
            drive(2, i < 10, (i < 10) ? w[i % 10] : 16'h0, 1'b1, 1'b0);
            #1;
            if (BYP ? (i < 10) : (i > 0)) begin
                n_tests++; if (o_valid[2] !== 1'b1 || o_data[2] !== w[BYP ? i : i - 1]) begin n_fail++; $display("FAIL wrap_data %0d got %b/%h want 1/%h", i, o_valid[2], o_data[2], w[BYP ? i : i - 1]); end
                n_tests++; if (cnt[2] !== (BYP ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL wrap_count %0d got %0d want %0d", i, cnt[2], BYP ? 0 : 1); end
            end
            tick();
        end
        drive(2, 1'b0, 16'h0, 1'b0, 1'b0);
        n_tests++; if (cnt[2] !== 3'd0) begin n_fail++; $display("FAIL wrap_end_count got %0d want 0", cnt[2]); end
    endtask

    task automatic test_full_simul();
        drive(3, 1'b1, 16'h0A01, 1'b0, 1'b0); tick();
        drive(3, 1'b1, 16'h0B02, 1'b0, 1'b0); tick();
        n_tests++; if (cnt[3] !== 3'd2) begin n_fail++; $display("FAIL simul_full_count got %0d want 2", cnt[3]); end
        drive(3, 1'b1, 16'h00AA, 1'b1, 1'b0);
        #1;
        n_tests++; if (i_ready[3] !== 1'b0 || o_data[3] !== 16'h0A01) begin n_fail++; $display("FAIL simul_head got ready %b data %h want 0/0a01", i_ready[3], o_data[3]); end
        tick();
        n_tests++; if (cnt[3] !== 3'd1 || o_data[3] !== 16'h0B02) begin n_fail++; $display("FAIL simul_pop got count %0d data %h want 1/0b02", cnt[3], o_data[3]); end
        drive(3, 1'b1, 16'h00AA, 1'b0, 1'b0);
        tick();
        n_tests++; if (cnt[3] !== 3'd2) begin n_fail++; $display("FAIL simul_accept got count %0d want 2", cnt[3]); end
        drive(3, 1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        n_tests++; if (o_data[3] !== 16'h00AA || o_valid[3] !== 1'b1) begin n_fail++; $display("FAIL simul_tail got %b/%h want 1/00aa", o_valid[3], o_data[3]); end
        tick();
        drive(3, 1'b0, 16'h0, 1'b0, 1'b0);
        n_tests++; if (cnt[3] !== 3'd0) begin n_fail++; $display("FAIL simul_end_count got %0d want 0", cnt[3]); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 16'(16'h41 + i), 1'b0, 1'b0);
            tick();
        end
        n_tests++; if (cnt[0] !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d want 3", cnt[0]); end
        drive(0, 1'b1, 16'h0077, 1'b0, 1'b1);
        tick();
        drive(0, 1'b0, 16'h0, 1'b1, 1'b0);
        #1;
        n_tests++; if (cnt[0] !== 3'd0 || o_valid[0] !== 1'b0) begin n_fail++; $display("FAIL flush_clear got count %0d valid %b want 0/0", cnt[0], o_valid[0]); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (o_valid[0] !== 1'b0) begin n_fail++; $display("FAIL flush_stale got valid %b data %h want 0", o_valid[0], o_data[0]); end
        end
        drive(0, 1'b1, 16'h0033, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 16'h0, 1'b1, 1'b0);
        #1;
        n_tests++; if (o_valid[0] !== 1'b1 || o_data[0] !== 16'h0033) begin n_fail++; $display("FAIL flush_refill got %b/%h want 1/0033", o_valid[0], o_data[0]); end
        tick();
        drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

`ifdef DTI_ELASTIC_FIFO_BYPASS_EN
    task automatic test_bypass();
        drive(0, 1'b1, 16'h005A, 1'b1, 1'b0);
        #1;
        n_tests++; if (o_valid[0] !== 1'b1 || o_data[0] !== 16'h005A || cnt[0] !== 3'd0) begin n_fail++; $display("FAIL bypass_pass got %b/%h count %0d want 1/005a/0", o_valid[0], o_data[0], cnt[0]); end
        tick();
        n_tests++; if (cnt[0] !== 3'd0) begin n_fail++; $display("FAIL bypass_nostore got count %0d want 0", cnt[0]); end
        drive(0, 1'b1, 16'h005A, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        n_tests++; if (cnt[0] !== 3'd1 || o_valid[0] !== 1'b1 || o_data[0] !== 16'h005A) begin n_fail++; $display("FAIL bypass_stall got count %0d %b/%h want 1/1/005a", cnt[0], o_valid[0], o_data[0]); end
        drive(0, 1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int g = 0; g < 4; g++) begin
            int d;
            d = DEPTHS[g];
            drive(g, 1'b0, 16'h0, 1'b0, 1'b1);
            tick();
            exp_q.delete();
            for (int c = 0; c < 300; c++) begin
                logic v, r, f, e_valid, e_ready;
                logic [15:0] dat, e_data;
                int m;
                v   = 1'($urandom_range(0, 1));
                r   = 1'($urandom_range(0, 1));
                f   = ($urandom_range(0, 24) == 0);
                dat = 16'($urandom);
                drive(g, v, dat, r, f);
                #1;
                m       = exp_q.size();
                e_ready = (m < d);
                e_valid = (m > 0) || (BYP && v);
                e_data  = (m > 0) ? exp_q[0] : dat;
                n_tests++; if (cnt[g] !== 3'(m)) begin n_fail++; $display("FAIL rand_count[%0d] cyc %0d got %0d want %0d", g, c, cnt[g], m); end
                n_tests++; if (i_ready[g] !== e_ready) begin n_fail++; $display("FAIL rand_ready[%0d] cyc %0d got %b want %b", g, c, i_ready[g], e_ready); end
                n_tests++; if (o_valid[g] !== e_valid) begin n_fail++; $display("FAIL rand_valid[%0d] cyc %0d got %b want %b", g, c, o_valid[g], e_valid); end
                n_tests++; if (af[g] !== (m >= d - 1)) begin n_fail++; $display("FAIL rand_af[%0d] cyc %0d got %b want %b", g, c, af[g], (m >= d - 1)); end
                if (e_valid) begin
                    n_tests++; if (o_data[g] !== e_data) begin n_fail++; $display("FAIL rand_data[%0d] cyc %0d got %h want %h", g, c, o_data[g], e_data); end
                end
                tick();
                if (f) begin
                    exp_q.delete();
                end else if (!(BYP && m == 0 && v && r)) begin
                    if (r && m > 0) void'(exp_q.pop_front());
                    if (v && e_ready) exp_q.push_back(dat);
                end
            end
            drive(g, 1'b0, 16'h0, 1'b0, 1'b1);
            tick();
            drive(g, 1'b0, 16'h0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_simul();
        test_flush();
`ifdef DTI_ELASTIC_FIFO_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
